// File: rtl/attex_bus_sequencer_if.sv
// ATTEX system-bus bundle: CPU strobes/address, CPU ack/err, DMA handshake,
// peripheral acknowledges and chip selects.
interface attex_bus_sequencer_if;
    logic        cpu_as;
    logic        cpu_uds;
    logic        cpu_lds;
    logic        cpu_write;
    logic [23:1] cpu_addr;
    logic        cpu_bus_ack;
    logic        cpu_bus_err;
    logic        dma_req;
    logic        dma_grant;
    logic        ack_mcd212;
    logic        ack_cdic;
    logic        ack_slave;
    logic        ack_mk48;
    logic        cs_mcd212;
    logic        cs_dvc;
    logic        cs_cdic;
    logic        cs_slave;
    logic        cs_mk48;
    logic        timeout_seen;

    // CPU, DMA requester and peripherals as seen from the outside world
    modport master (
        output cpu_as, cpu_uds, cpu_lds, cpu_write, cpu_addr, dma_req,
               ack_mcd212, ack_cdic, ack_slave, ack_mk48,
        input  cpu_bus_ack, cpu_bus_err, dma_grant,
               cs_mcd212, cs_dvc, cs_cdic, cs_slave, cs_mk48, timeout_seen
    );

    // the sequencer itself
    modport slave (
        input  cpu_as, cpu_uds, cpu_lds, cpu_write, cpu_addr, dma_req,
               ack_mcd212, ack_cdic, ack_slave, ack_mk48,
        output cpu_bus_ack, cpu_bus_err, dma_grant,
               cs_mcd212, cs_dvc, cs_cdic, cs_slave, cs_mk48, timeout_seen
    );
endinterface

// File: rtl/attex_bus_sequencer.sv
// ATTEX bus sequencer: decodes each CPU cycle once, holds a registered chip
// select for the whole cycle, returns a one-cycle ack/err, guards against a
// missing DTACK with a watchdog, and shares the bus with the CDIC DMA channel
// under a bounded hold so the CPU cannot be starved.
module attex_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DMA_HOLD_MAX   = 16
) (
    input  logic                  clk30,
    input  logic                  reset,
    attex_bus_sequencer_if.slave  bus
);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(DMA_HOLD_MAX + 1);

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        CPU_WAIT = 5'b00010,
        ERR      = 5'b00100,
        CPU_END  = 5'b01000,
        DMA      = 5'b10000
    } state_t;

    typedef struct packed {
        logic mcd212;
        logic dvc;
        logic cdic;
        logic slave;
        logic mk48;
    } sel_t;

    state_t            state, state_nx;
    sel_t              dec, sel_q, sel_nx, cs_q, cs_nx;
    logic              dec_err;
    logic [23:0]       addr;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic              pend_block, pend_block_nx;
    logic              ack_q, ack_nx;
    logic              err_q, err_nx;
    logic              tmo_q, tmo_nx;
    logic              grant_q, grant_nx;
    logic              cpu_req, sel_ack;
    logic              unused_write;

    // write direction does not influence routing or timing
    assign unused_write = bus.cpu_write;

    assign addr    = {bus.cpu_addr, 1'b0};
    assign cpu_req = bus.cpu_as && (bus.cpu_uds || bus.cpu_lds);

    // MCD212 and DVC RAM share one acknowledge line
    assign sel_ack = ((sel_q.mcd212 || sel_q.dvc) && bus.ack_mcd212)
                   || (sel_q.cdic  && bus.ack_cdic)
                   || (sel_q.slave && bus.ack_slave)
                   || (sel_q.mk48  && bus.ack_mk48);

    // address decode on the byte address, first match wins
    always_comb begin
        dec     = '0;
        dec_err = 1'b0;
        if ((addr >= 24'h600000 && addr <= 24'hCFFFFF) || addr >= 24'hF00000)
            dec_err = 1'b1;
        else if (addr[23:16] == 8'h30)
            dec.cdic = 1'b1;
        else if (addr[23:16] == 8'h31)
            dec.slave = 1'b1;
        else if (addr[23:16] == 8'h32)
            dec.mk48 = 1'b1;
        else if (addr[23:20] == 4'hD || addr[23:19] == 5'b11101)
            dec.dvc = 1'b1;
        else if (addr <= 24'h27FFFF || (addr >= 24'h400000 && addr < 24'h600000))
            dec.mcd212 = 1'b1;
        else
            dec_err = 1'b1;
    end

    // next-state and registered-output logic
    always_comb begin
        state_nx      = state;
        sel_nx        = sel_q;
        wd_cnt_nx     = wd_cnt;
        hold_cnt_nx   = hold_cnt;
        pend_block_nx = pend_block;
        ack_nx        = 1'b0;
        err_nx        = 1'b0;
        tmo_nx        = tmo_q;
        unique case (state)
            IDLE: begin
                // a pending block after a forced DMA release hands the bus to the CPU
                if (cpu_req && (!bus.dma_req || pend_block)) begin
                    pend_block_nx = 1'b0;
                    wd_cnt_nx     = '0;
                    if (dec_err) begin
                        sel_nx   = '0;
                        err_nx   = 1'b1;
                        state_nx = ERR;
                    end else begin
                        sel_nx   = dec;
                        state_nx = CPU_WAIT;
                    end
                end else if (bus.dma_req) begin
                    hold_cnt_nx = '0;
                    state_nx    = DMA;
                end
            end
            CPU_WAIT: begin
                wd_cnt_nx = (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;
                // an ack on the timeout cycle still wins over the error
                if (sel_ack) begin
                    ack_nx   = 1'b1;
                    state_nx = CPU_END;
                end else if (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nx   = 1'b1;
                    tmo_nx   = 1'b1;
                    state_nx = CPU_END;
                end
            end
            ERR: begin
                state_nx = CPU_END;
            end
            CPU_END: begin
                // AS must drop before another cycle can be decoded
                if (!bus.cpu_as)
                    state_nx = IDLE;
            end
            DMA: begin
                if (!bus.dma_req) begin
                    hold_cnt_nx   = '0;
                    pend_block_nx = 1'b0;
                    state_nx      = IDLE;
                end else if (cpu_req) begin
                    if (hold_cnt == HOLD_W'(DMA_HOLD_MAX - 1)) begin
                        hold_cnt_nx   = '0;
                        pend_block_nx = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        hold_cnt_nx = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        cs_nx    = (state_nx == CPU_WAIT) ? sel_nx : '0;
        grant_nx = (state_nx == DMA);
    end

    // state and output registers, synchronous reset
    always_ff @(posedge clk30) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= '0;
            cs_q       <= '0;
            wd_cnt     <= '0;
            hold_cnt   <= '0;
            pend_block <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            sel_q      <= sel_nx;
            cs_q       <= cs_nx;
            wd_cnt     <= wd_cnt_nx;
            hold_cnt   <= hold_cnt_nx;
            pend_block <= pend_block_nx;
            ack_q      <= ack_nx;
            err_q      <= err_nx;
            tmo_q      <= tmo_nx;
            grant_q    <= grant_nx;
        end
    end

    assign bus.cpu_bus_ack  = ack_q;
    assign bus.cpu_bus_err  = err_q;
    assign bus.dma_grant    = grant_q;
    assign bus.timeout_seen = tmo_q;
    assign bus.cs_mcd212    = cs_q.mcd212;
    assign bus.cs_dvc       = cs_q.dvc;
    assign bus.cs_cdic      = cs_q.cdic;
    assign bus.cs_slave     = cs_q.slave;
    assign bus.cs_mk48      = cs_q.mk48;
endmodule

// File: tb/tb_attex_bus_sequencer.sv
// Randomized bench for attex_bus_sequencer: each CPU access is predicted at
// transaction level (which select, how many select cycles, when ack/err lands)
// from the address map and ack delay, plus directed DMA-hold and reset cases.
module tb_attex_bus_sequencer;
    localparam int TO   = 40;
    localparam int HOLD = 16;
    localparam int NONE = 100000;

    logic clk30 = 1'b0;
    logic reset = 1'b1;
    logic [3:0] ack_drv = '0;   // {mcd212, cdic, slave, mk48}
    logic [4:0] cs_obs;         // {mcd212, dvc, cdic, slave, mk48}
    logic [8:0] outs_obs;

    int  n_chk = 0;
    int  n_err = 0;
    bit  model_tmo = 0;

    attex_bus_sequencer_if bus();

    attex_bus_sequencer #(.TIMEOUT_CYCLES(TO), .DMA_HOLD_MAX(HOLD)) dut (
        .clk30 (clk30),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk30 = ~clk30;

    assign bus.ack_mcd212 = ack_drv[3];
    assign bus.ack_cdic   = ack_drv[2];
    assign bus.ack_slave  = ack_drv[1];
    assign bus.ack_mk48   = ack_drv[0];
    assign cs_obs   = {bus.cs_mcd212, bus.cs_dvc, bus.cs_cdic, bus.cs_slave, bus.cs_mk48};
    assign outs_obs = {bus.cpu_bus_ack, bus.cpu_bus_err, bus.dma_grant, cs_obs, bus.timeout_seen};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // address map as plain byte-address ranges; 0 means error region
    function automatic logic [4:0] ref_sel(input int a);
        if ((a >= 'h600000 && a < 'hD00000) || a >= 'hF00000) return 5'b00000;
        if (a >= 'h300000 && a < 'h310000) return 5'b00100;
        if (a >= 'h310000 && a < 'h320000) return 5'b00010;
        if (a >= 'h320000 && a < 'h330000) return 5'b00001;
        if ((a >= 'hD00000 && a < 'hE00000) || (a >= 'hE80000 && a < 'hF00000)) return 5'b01000;
        if (a < 'h280000 || (a >= 'h400000 && a < 'h600000)) return 5'b10000;
        return 5'b00000;
    endfunction

    function automatic logic [3:0] ack_of(input logic [4:0] s);
        if (s == 5'b10000 || s == 5'b01000) return 4'b1000;
        if (s == 5'b00100) return 4'b0100;
        if (s == 5'b00010) return 4'b0010;
        if (s == 5'b00001) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic drive_start(input int a);
        logic [23:0] ab;
        logic [1:0]  st;
        ab = 24'(a);
        st = 2'($urandom_range(1, 3));
        bus.cpu_addr  = ab[23:1];
        bus.cpu_uds   = st[1];
        bus.cpu_lds   = st[0];
        bus.cpu_write = 1'($urandom);
        bus.cpu_as    = 1'b1;
    endtask

    // one CPU access: ack driven d cycles after the first select cycle,
    // AS kept h cycles past the response, unrelated acks toggled randomly
    task automatic cpu_txn(input int a, input int d, input int h);
        logic [4:0] es;
        logic [3:0] eack;
        int r, exp_cs, last;
        int cs_first, cs_cnt, cs_oth, ack_at, ack_cnt, err_at, err_cnt, gnt_cnt;
        bit to_exp, is_ack;
        es = ref_sel(a);
        eack = ack_of(es);
        to_exp = 0; is_ack = 0;
        cs_first = 0; cs_cnt = 0; cs_oth = 0; ack_at = 0; ack_cnt = 0;
        err_at = 0; err_cnt = 0; gnt_cnt = 0;
        if (es == 5'b0) begin
            r = 1; exp_cs = 0;
        end else if (d <= TO - 1) begin
            r = d + 2; exp_cs = d + 1; is_ack = 1;
        end else begin
            r = TO + 1; exp_cs = TO; to_exp = 1;
        end
        last = r + h + 3;
        @(negedge clk30);
        drive_start(a);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk30);
            if ((cs_obs & es) != 5'b0) begin
                cs_cnt++;
                if (cs_first == 0) cs_first = n;
            end
            if ((cs_obs & ~es) != 5'b0) cs_oth++;
            if (bus.cpu_bus_ack) begin ack_cnt++; if (ack_at == 0) ack_at = n; end
            if (bus.cpu_bus_err) begin err_cnt++; if (err_at == 0) err_at = n; end
            if (bus.dma_grant) gnt_cnt++;
            ack_drv = 4'($urandom) & ~eack;
            if (n == d + 1) ack_drv = ack_drv | eack;
            if (n >= r + h) bus.cpu_as = 1'b0;
        end
        ack_drv = '0;
        bus.cpu_uds = 1'b0;
        bus.cpu_lds = 1'b0;
        if (to_exp) model_tmo = 1;
        chk("cs_first", cs_first, (es != 5'b0) ? 1 : 0);
        chk("cs_cycles", cs_cnt, exp_cs);
        chk("cs_wrong", cs_oth, 0);
        chk("ack_at", ack_at, is_ack ? r : 0);
        chk("ack_cnt", ack_cnt, is_ack ? 1 : 0);
        chk("err_at", err_at, is_ack ? 0 : r);
        chk("err_cnt", err_cnt, is_ack ? 0 : 1);
        chk("grant_in_cpu", gnt_cnt, 0);
        chk("timeout_seen", bus.timeout_seen, model_tmo);
    endtask

    // DMA and CPU start together, dma_req held 40 cycles: DMA holds 16
    // cycles, CPU is forced in, then DMA is granted again until req drops
    task automatic dma_txn(input int d);
        int gnt1, gnt_tot, g2_first, cs_first, ack_at, overlap;
        gnt1 = 0; gnt_tot = 0; g2_first = 0; cs_first = 0; ack_at = 0; overlap = 0;
        @(negedge clk30);
        drive_start('h300000);
        bus.dma_req = 1'b1;
        for (int n = 1; n <= 46; n++) begin
            @(negedge clk30);
            if (bus.dma_grant) begin
                gnt_tot++;
                if (n <= 17) gnt1++;
                else if (g2_first == 0) g2_first = n;
            end
            if (cs_obs != 5'b0 && bus.dma_grant) overlap++;
            if (cs_obs != 5'b0 && cs_first == 0) cs_first = n;
            if (bus.cpu_bus_ack && ack_at == 0) ack_at = n;
            ack_drv = (n == 18 + d) ? 4'b0100 : 4'b0000;
            if (n == 20 + d) bus.cpu_as = 1'b0;
            if (n == 40) bus.dma_req = 1'b0;
        end
        ack_drv = '0;
        bus.cpu_uds = 1'b0;
        bus.cpu_lds = 1'b0;
        chk("dma_hold", gnt1, HOLD);
        chk("dma_cpu_cs", cs_first, 18);
        chk("dma_cpu_ack", ack_at, 19 + d);
        chk("dma_regrant", g2_first, 22 + d);
        chk("dma_total", gnt_tot, 35 - d);
        chk("dma_cs_overlap", overlap, 0);
    endtask

    int tbl[23] = '{'h000000, 'h27FFFE, 'h280000, 'h2FFFFE, 'h300000, 'h30FFFE,
                    'h310000, 'h320000, 'h32FFFE, 'h330000, 'h3FFFFE, 'h400000,
                    'h5FFFFE, 'h600000, 'hCFFFFE, 'hD00000, 'hDFFFFE, 'hE00000,
                    'hE7FFFE, 'hE80000, 'hEFFFFE, 'hF00000, 'hFFFFFE};

    initial begin
        int cnt;
        bus.cpu_as = 1'b0; bus.cpu_uds = 1'b0; bus.cpu_lds = 1'b0;
        bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.dma_req = 1'b0;
        repeat (3) @(negedge clk30);
        chk("reset_outs", outs_obs, 9'd0);
        reset = 1'b0;
        @(negedge clk30);

        // directed cases from the address map and watchdog rules
        cpu_txn('h300000, 2, 0);
        cpu_txn('h600000, 0, 1);
        cpu_txn('hE80000, 1, 0);
        cpu_txn('h320000, NONE, 0);
        cpu_txn('h320000, TO - 1, 0);
        cpu_txn('h300000, 1, 3);

        // AS without data strobes never starts a cycle
        @(negedge clk30);
        bus.cpu_addr = 23'h180000; bus.cpu_as = 1'b1;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk30);
            if (outs_obs[8:1] != 8'd0) cnt++;
        end
        bus.cpu_as = 1'b0;
        chk("no_strobe_idle", cnt, 0);
        @(negedge clk30);

        // reset in the middle of a CDIC wait
        @(negedge clk30);
        drive_start('h300000);
        cnt = 0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk30);
            if (bus.cs_cdic) cnt++;
        end
        chk("rst_pre_cs", cnt, 3);
        chk("rst_pre_tmo", bus.timeout_seen, 1);
        reset = 1'b1; bus.cpu_as = 1'b0; bus.cpu_uds = 1'b0; bus.cpu_lds = 1'b0;
        @(negedge clk30);
        chk("rst_mid_outs", outs_obs, 9'd0);
        reset = 1'b0;
        model_tmo = 0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk30);
            if (outs_obs != 9'd0) cnt++;
        end
        chk("rst_after_quiet", cnt, 0);

        dma_txn(int'($urandom_range(0, 3)));
        dma_txn(int'($urandom_range(0, 3)));

        // randomized accesses
        for (int i = 0; i < 150; i++) begin
            int a, d, r;
            if ($urandom_range(0, 9) < 7) a = tbl[$urandom_range(0, 22)];
            else a = int'($urandom & 32'h00FFFFFE);
            r = int'($urandom_range(0, 9));
            if (r <= 5) d = r;
            else if (r == 6) d = TO - 1;
            else if (r == 7) d = TO - 2;
            else d = NONE;
            cpu_txn(a, d, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/attex_bus_sequencer.md
Name: attex_bus_sequencer

Overview:
Registered system-bus controller between the SCC68070 bus master, the CDIC DMA requester and the ATTEX peripherals: MCD212, DVC RAM, CDIC, slave µC and MK48 NVRAM.
- Decodes each cycle once and holds the chip select stable for the whole cycle.
- Returns a single-cycle bus_ack or bus_err to the CPU.
- Enforces a DTACK watchdog so a missing peripheral acknowledge cannot hang the CPU.
- Arbitrates bus ownership with the DMA channel, with a bounded DMA hold so the CPU is never starved.

Parameters:
TIMEOUT_CYCLES, 1024, clk30 cycles a CPU cycle may wait for a peripheral ack before bus_err.
DMA_HOLD_MAX, 16, maximum consecutive granted cycles for DMA while the CPU has a cycle pending.

Ports:
clk30  input  1  system clock
reset  input  1  synchronous, active-high
cpu_as  input  1  CPU address strobe
cpu_uds  input  1  upper data strobe
cpu_lds  input  1  lower data strobe
cpu_write  input  1  CPU write strobe
cpu_addr  input  23  CPU word address [23:1]
cpu_bus_ack  output  1  one-cycle acknowledge to CPU
cpu_bus_err  output  1  one-cycle bus error to CPU
dma_req  input  1  DMA requests bus
dma_grant  output  1  DMA owns bus
ack_mcd212  input  1  MCD212/DVC ack
ack_cdic  input  1  CDIC ack
ack_slave  input  1  slave µC ack
ack_mk48  input  1  NVRAM ack
cs_mcd212  output  1  MCD212 select
cs_dvc  output  1  DVC RAM select
cs_cdic  output  1  CDIC select
cs_slave  output  1  slave select
cs_mk48  output  1  NVRAM select
timeout_seen  output  1  sticky flag: a watchdog timeout occurred since reset

Behaviour:
Reset and clocking:
- All logic is clocked on clk30.
- reset is synchronous, active-high.
- Under reset, every output is 0 and the state is IDLE.
- Reset mid-cycle aborts the cycle; no ack or error is emitted.

Address decode, on byte address A = {cpu_addr,0}, first match wins:
1. Error region: A in 0x600000–0xCFFFFF or A >= 0xF00000.
2. cs_cdic: A[23:16] = 0x30.
3. cs_slave: A[23:16] = 0x31.
4. cs_mk48: A[23:16] = 0x32.
5. cs_dvc: A[23:20] = 0xD, or A[23:19] = 5'b11101.
6. cs_mcd212: A <= 0x27FFFF, or 0x400000 <= A < 0x600000.
7. Anything else: error region.

Cycle start condition: cpu_as && (cpu_uds || cpu_lds) while in IDLE.

State machine, one-hot CS, encoding free:
- IDLE
  - Start condition and !dma_req: latch the decode; go to CPU_WAIT if mapped, ERR if in the error region.
  - dma_req and no start condition: go to DMA.
  - dma_req and start condition on the same edge: DMA wins, unless pend_block is set (see DMA).
- CPU_WAIT
  - Exactly one cs_* is high, starting the cycle after the start edge.
  - The watchdog counter increments each cycle; its width is clog2(TIMEOUT_CYCLES+1), and it saturates rather than wrapping.
  - Selected ack high: cpu_bus_ack = 1 for exactly the next cycle; drop cs; go to CPU_END. Acks of unselected peripherals are ignored.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: cpu_bus_err = 1 for one cycle; set timeout_seen; drop cs; go to CPU_END.
  - An ack arriving on the same cycle as the timeout takes precedence: ack, no error.
- ERR
  - cpu_bus_err = 1 for one cycle, emitted on the cycle after the start edge; no cs asserted.
  - Then go to CPU_END.
- CPU_END
  - Wait for cpu_as = 0, then go to IDLE.
  - An AS still held never starts a second cycle.
- DMA
  - dma_grant = 1.
  - Hold counter counts granted cycles while a CPU cycle is pending (start condition true).
  - dma_req = 0: go to IDLE the next cycle.
  - Hold counter = DMA_HOLD_MAX: set pend_block; drop the grant; go to IDLE.
  - pend_block forces the next IDLE arbitration to the CPU; it clears when that CPU cycle starts.
  - Both the hold counter and pend_block clear on leaving DMA for any other reason.
- cs_* are never asserted while dma_grant = 1.

Latency and invariants:
- Minimum CPU cycle: start edge → cs next cycle → ack seen → cpu_bus_ack one cycle later, giving 3 cycles with a zero-wait ack.
- cpu_bus_ack and cpu_bus_err are never high on the same cycle.

Test Plan:
- Read at 0x300000, ack_cdic raised 2 cycles after cs_cdic -> cs_cdic only; cpu_bus_ack one pulse 1 cycle after ack; no error; IDLE after cpu_as falls.
- Access at 0x600000 -> no cs; cpu_bus_err one pulse on the cycle after start; access at 0xE80000 -> cs_dvc asserted.
- Access at 0x320000 with ack_mk48 never asserted -> cpu_bus_err after TIMEOUT_CYCLES cycles; timeout_seen = 1 and stays set; ack arriving on the timeout cycle -> ack only.
- dma_req and CPU start on the same edge, dma_req held 40 cycles -> dma_grant for 16 cycles, then released; CPU cycle is serviced; dma_grant re-asserted afterwards.
- Assert reset during CPU_WAIT with cs_cdic high -> all outputs 0 next cycle; no ack or error; timeout_seen cleared.
- cpu_as held high across the ack, plus a spurious ack_slave during a CDIC cycle -> exactly one cpu_bus_ack; spurious ack ignored; no second cycle starts.
